// File: rtl/channel_accumulator.sv
// Per-channel windowed accumulator feeding a hold bank that is streamed out one channel per beat.
// A window closing while the previous one is still being read out is dropped and flagged on overrun.
module channel_accumulator #(
  parameter int NUM_CHANNELS  = 8,
  parameter int CHANNEL_WIDTH = 16,
  parameter int WINDOW_WIDTH  = 16,
  parameter int ACC_WIDTH     = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [WINDOW_WIDTH-1:0]               windowLength,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] logicalData,
  input  logic [NUM_CHANNELS-1:0]               logicalValid,
  input  logic                                  clearOverrun,
  output logic [ACC_WIDTH-1:0]                  outData,
  output logic [2:0]                            outChannel,
  output logic [15:0]                           outSeq,
  output logic                                  outValid,
  output logic                                  outLast,
  input  logic                                  outReady,
  output logic                                  overrun
);

  // state | meaning
  // IDLE  | accumulating, hold bank free for the next closing window
  // DUMP  | hold bank streaming out, one channel per beat
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DUMP = 1'b1;
  localparam logic [2:0] LAST_IDX = 3'(NUM_CHANNELS - 1);

  logic [0:0]                     state;
  logic [2:0]                     idx;
  logic [WINDOW_WIDTH-1:0]        latchedLength;
  logic [WINDOW_WIDTH-1:0]        sampleCount;
  logic [WINDOW_WIDTH-1:0]        lastCount;
  logic [15:0]                    windowSeq;
  logic [15:0]                    holdSeq;
  logic signed [CHANNEL_WIDTH-1:0] sampleIn [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0]    acc      [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0]    accNext  [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0]    hold     [NUM_CHANNELS];
  logic                           sampleEvent;
  logic                           windowClose;
  logic                           dropWindow;
  logic                           beatXfer;
  logic                           lastBeat;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sampleIn[i] = logicalData[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      accNext[i]  = acc[i];
      if (logicalValid[i]) begin
        accNext[i] = acc[i] + ACC_WIDTH'(sampleIn[i]);
      end
    end
  end

  // A latched length of zero behaves exactly like a length of one.
  assign lastCount   = (latchedLength == '0) ? '0 : latchedLength - WINDOW_WIDTH'(1);
  assign sampleEvent = logicalValid[0];
  assign windowClose = sampleEvent && (sampleCount == lastCount);
  assign dropWindow  = windowClose && (state == DUMP);
  assign lastBeat    = (idx == LAST_IDX);
  assign beatXfer    = (state == DUMP) && outReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      sampleCount   <= '0;
      latchedLength <= windowLength;
      windowSeq     <= '0;
      holdSeq       <= '0;
      overrun       <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        acc[i]  <= '0;
        hold[i] <= '0;
      end
    end else begin
      if (beatXfer) begin
        if (lastBeat) begin
          idx   <= '0;
          state <= IDLE;
        end else begin
          idx <= idx + 3'd1;
        end
      end

      if (windowClose) begin
        sampleCount   <= '0;
        latchedLength <= windowLength;
        windowSeq     <= windowSeq + 16'd1;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          acc[i] <= '0;
        end
        if (state == IDLE) begin
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            hold[i] <= accNext[i];
          end
          holdSeq <= windowSeq;
          idx     <= '0;
          state   <= DUMP;
        end
      end else begin
        if (sampleEvent) begin
          sampleCount <= sampleCount + WINDOW_WIDTH'(1);
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          acc[i] <= accNext[i];
        end
      end

      // Setting has priority over a coincident clear.
      if (dropWindow) begin
        overrun <= 1'b1;
      end else if (clearOverrun) begin
        overrun <= 1'b0;
      end
    end
  end

  assign outValid   = (state == DUMP);
  assign outData    = outValid ? hold[idx] : '0;
  assign outChannel = idx;
  assign outSeq     = holdSeq;
  assign outLast    = outValid && lastBeat;

endmodule

// File: tb/tb_channel_accumulator.sv
// Self-checking bench for channel_accumulator: directed table, corner sequences and randomized traffic
// compared against a window/beat-level reference model.
module tb_channel_accumulator;

  localparam int NCH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   windowLength = '0;
  logic [127:0]  logicalData = '0;
  logic [7:0]    logicalValid = '0;
  logic          clearOverrun = 1'b0;
  logic          outReady = 1'b0;
  logic [31:0]   outData;
  logic [2:0]    outChannel;
  logic [15:0]   outSeq;
  logic          outValid;
  logic          outLast;
  logic          overrun;

  shortint dIn [NCH];
  int nTests = 0;
  int nFail = 0;

  // reference model state
  bit     modelOn = 0;
  longint modelAcc [NCH];
  longint expWin [NCH];
  int     modelCnt, modelLen, modelSeq, expSeq, beatsLeft;
  bit     modelOvr;

  typedef struct {
    int         wlen;
    logic [7:0] mask;
    int         base;
    int         step;
    int         expSum [NCH];
  } vecT;
  vecT vecs [5];

  channel_accumulator dut (
    .clk(clk), .reset(reset), .windowLength(windowLength),
    .logicalData(logicalData), .logicalValid(logicalValid), .clearOverrun(clearOverrun),
    .outData(outData), .outChannel(outChannel), .outSeq(outSeq), .outValid(outValid),
    .outLast(outLast), .outReady(outReady), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint want);
    nTests++;
    if (act != want) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic modelUpdate();
    longint nxt [NCH];
    int eff;
    bit close, busy;
    if (reset) begin
      for (int i = 0; i < NCH; i++) modelAcc[i] = 0;
      modelCnt = 0; modelLen = int'(windowLength); modelSeq = 0; expSeq = 0;
      beatsLeft = 0; modelOvr = 0; modelOn = 1;
      return;
    end
    if (!modelOn) return;
    busy = (beatsLeft > 0);
    for (int i = 0; i < NCH; i++)
      nxt[i] = modelAcc[i] + (logicalValid[i] ? longint'(dIn[i]) : 64'sd0);
    eff = (modelLen == 0) ? 1 : modelLen;
    close = logicalValid[0] && (modelCnt == eff - 1);
    if (busy && outReady) beatsLeft--;
    if (close) begin
      if (busy) modelOvr = 1;
      else begin
        for (int i = 0; i < NCH; i++) expWin[i] = nxt[i];
        expSeq = modelSeq;
        beatsLeft = NCH;
      end
      modelSeq = (modelSeq + 1) % 65536;
      modelCnt = 0;
      modelLen = int'(windowLength);
      for (int i = 0; i < NCH; i++) modelAcc[i] = 0;
    end else begin
      if (logicalValid[0]) modelCnt++;
      for (int i = 0; i < NCH; i++) modelAcc[i] = nxt[i];
    end
    if (!(close && busy) && clearOverrun) modelOvr = 0;
  endtask

  task automatic modelCheck();
    int b;
    if (beatsLeft > 0) begin
      b = NCH - beatsLeft;
      chk("m_valid", outValid, 1);
      chk("m_data", $signed(outData), expWin[b]);
      chk("m_chan", outChannel, b);
      chk("m_seq", outSeq, expSeq);
      chk("m_last", outLast, (beatsLeft == 1));
    end else begin
      chk("m_idle_valid", outValid, 0);
      chk("m_idle_last", outLast, 0);
    end
    chk("m_overrun", overrun, modelOvr);
  endtask

  task automatic cycle();
    for (int i = 0; i < NCH; i++) logicalData[i*16 +: 16] = dIn[i];
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    if (modelOn) modelCheck();
  endtask

  task automatic idle(input int n);
    logicalValid = '0;
    repeat (n) cycle();
  endtask

  task automatic feed(input logic [7:0] mask, input int base, input int step, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NCH; i++) dIn[i] = shortint'(base + i * step);
      logicalValid = mask;
      cycle();
    end
    logicalValid = '0;
  endtask

  task automatic resetDut(input int len);
    reset = 1'b1;
    windowLength = 16'(len);
    logicalValid = '0;
    clearOverrun = 1'b0;
    cycle();
    reset = 1'b0;
    chk("rst_valid", outValid, 0);
    chk("rst_last", outLast, 0);
    chk("rst_data", outData, 0);
    chk("rst_chan", outChannel, 0);
    chk("rst_seq", outSeq, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) dIn[i] = 0;

    vecs[0].wlen = 4; vecs[0].mask = 8'hff; vecs[0].base = 1;      vecs[0].step = 1;
    vecs[0].expSum = '{4, 8, 12, 16, 20, 24, 28, 32};
    vecs[1].wlen = 3; vecs[1].mask = 8'h05; vecs[1].base = 10;     vecs[1].step = 0;
    vecs[1].expSum = '{30, 0, 30, 0, 0, 0, 0, 0};
    vecs[2].wlen = 0; vecs[2].mask = 8'hff; vecs[2].base = -5;     vecs[2].step = 2;
    vecs[2].expSum = '{-5, -3, -1, 1, 3, 5, 7, 9};
    vecs[3].wlen = 1; vecs[3].mask = 8'h81; vecs[3].base = 100;    vecs[3].step = -10;
    vecs[3].expSum = '{100, 0, 0, 0, 0, 0, 0, 30};
    vecs[4].wlen = 2; vecs[4].mask = 8'hff; vecs[4].base = -32768; vecs[4].step = 0;
    vecs[4].expSum = '{-65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536};

    // directed table
    for (int v = 0; v < 5; v++) begin
      int n;
      outReady = 1'b1;
      resetDut(vecs[v].wlen);
      n = (vecs[v].wlen == 0) ? 1 : vecs[v].wlen;
      for (int k = 0; k < n; k++) begin
        chk("tbl_pre_valid", outValid, 0);
        feed(vecs[v].mask, vecs[v].base, vecs[v].step, 1);
      end
      for (int b = 0; b < NCH; b++) begin
        chk("tbl_valid", outValid, 1);
        chk("tbl_chan", outChannel, b);
        chk("tbl_data", $signed(outData), vecs[v].expSum[b]);
        chk("tbl_last", outLast, (b == NCH - 1));
        chk("tbl_seq", outSeq, 0);
        idle(1);
      end
      chk("tbl_done", outValid, 0);
    end

    // full-length window at the signed extremes
    outReady = 1'b1;
    resetDut(65535);
    feed(8'h03, -32768, 65535, 65535);
    chk("wide_ch0", $signed(outData), -64'sd2147450880);
    idle(1);
    chk("wide_ch1", $signed(outData), 64'sd2147385345);
    idle(7);

    // backpressure, dropped window, sequence gap, overrun clear
    outReady = 1'b1;
    resetDut(2);
    outReady = 1'b0;
    feed(8'hff, 5, 1, 2);
    chk("bp_valid", outValid, 1);
    chk("bp_first", $signed(outData), 10);
    feed(8'hff, 100, 0, 2);
    chk("bp_hold_data", $signed(outData), 10);
    chk("bp_hold_chan", outChannel, 0);
    chk("bp_overrun", overrun, 1);
    outReady = 1'b1;
    for (int b = 0; b < NCH; b++) begin
      chk("bp_seq0", outSeq, 0);
      chk("bp_data", $signed(outData), 2 * (5 + b));
      idle(1);
    end
    chk("bp_sticky", overrun, 1);
    feed(8'hff, 1, 0, 2);
    chk("bp_seq2", outSeq, 2);
    chk("bp_next_data", $signed(outData), 2);
    idle(8);
    clearOverrun = 1'b1;
    idle(1);
    clearOverrun = 1'b0;
    chk("bp_cleared", overrun, 0);

    // non-zero channels valid without channel 0 never close a window
    resetDut(1);
    for (int k = 0; k < 3; k++) begin
      feed(8'h02, 9, 0, 1);
      chk("ch1_only_no_close", outValid, 0);
    end
    feed(8'h01, 4, 0, 1);
    chk("ch1_close_valid", outValid, 1);
    chk("ch1_close_ch0", $signed(outData), 4);
    idle(1);
    chk("ch1_accum", $signed(outData), 27);
    idle(7);

    // window length change mid-window
    resetDut(4);
    feed(8'hff, 1, 0, 2);
    windowLength = 16'd2;
    feed(8'hff, 1, 0, 2);
    chk("len_old_valid", outValid, 1);
    chk("len_old_sum", $signed(outData), 4);
    idle(8);
    feed(8'hff, 1, 0, 2);
    chk("len_new_valid", outValid, 1);
    chk("len_new_sum", $signed(outData), 2);
    idle(8);

    // reset during beat 3 discards readout and partial window
    resetDut(2);
    feed(8'hff, 7, 0, 2);
    chk("rmr_first", $signed(outData), 14);
    idle(2);
    feed(8'hff, 50, 0, 1);
    chk("rmr_beat3", outChannel, 3);
    resetDut(2);
    feed(8'hff, 3, 0, 2);
    chk("rmr_post_valid", outValid, 1);
    chk("rmr_post_sum", $signed(outData), 6);
    chk("rmr_post_seq", outSeq, 0);
    idle(8);

    // randomized traffic against the reference model
    resetDut(3);
    for (int c = 0; c < 4000; c++) begin
      logicalValid = 8'($urandom);
      for (int i = 0; i < NCH; i++) dIn[i] = shortint'($urandom);
      outReady = ($urandom_range(0, 9) < 7);
      clearOverrun = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) windowLength = 16'($urandom_range(0, 12));
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;
    clearOverrun = 1'b0;
    idle(12);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
